tlc_multiway: RTL and testbench



---
 rtl/tlc_pkg.sv | 17 +
 rtl/tlc_multiway_rr_next_dir.sv | 47 ++++
 rtl/tlc_multiway.sv | 154 +++++++++++++++
 tb/tb_tlc_multiway.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-approach traffic light controller:
// controller state encoding and direction-index width helper.
package tlc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_GREEN  = 3'd0;
  localparam state_t ST_YELLOW = 3'd1;
  localparam state_t ST_ALLRED = 3'd2;
  localparam state_t ST_FLASH  = 3'd3;

  // Width of a direction index; a two-way junction still needs one bit.
  function automatic int dirWidth(input int nDir);
    return (nDir <= 2) ? 1 : $clog2(nDir);
  endfunction

endpackage

// File: rtl/tlc_multiway_rr_next_dir.sv
// Combinational round-robin picker: first requesting index after cur,
// wrapping modulo N_DIR; returns cur itself when nobody else is requesting.
module rr_next_dir
  import tlc_pkg::*;
#(
  parameter int N_DIR = 4,
  parameter int DW    = dirWidth(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [DW-1:0]    cur,
  output logic [DW-1:0]    nextIdx,
  output logic             anyReq
);

  localparam logic [N_DIR-1:0] ONE_HOT0 = {{(N_DIR-1){1'b0}}, 1'b1};
  localparam logic [DW:0]      N_WRAP   = (DW+1)'(N_DIR);

  logic [DW:0]   sum_s;
  logic [DW-1:0] idx_s;
  logic          found_s;

  // Scan offsets 1..N_DIR-1 from cur, keeping the first hit.
  always_comb begin
    nextIdx = cur;
    found_s = 1'b0;
    sum_s   = {(DW+1){1'b0}};
    idx_s   = {DW{1'b0}};
    for (int k = 1; k < N_DIR; k++) begin
      sum_s = {1'b0, cur} + (DW+1)'(k);
      if (sum_s >= N_WRAP) begin
        sum_s = sum_s - N_WRAP;
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[DW-1:0];
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        nextIdx = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign anyReq = |(req & ~(ONE_HOT0 << cur));

endmodule

// File: rtl/tlc_multiway.sv
// N-approach round-robin traffic light controller with min/max green,
// yellow and all-red clearance, idle-direction skipping and night flash.
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int N_DIR      = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int FLASH_HALF = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           car,
  input  logic                       night,
  output logic [N_DIR-1:0]           green,
  output logic [N_DIR-1:0]           yellow,
  output logic [N_DIR-1:0]           red,
  output logic [dirWidth(N_DIR)-1:0] cur_dir,
  output logic [2:0]                 phase
);

  localparam int DW = dirWidth(N_DIR);

  localparam logic [N_DIR-1:0] ONE_HOT0  = {{(N_DIR-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FH_LAST   = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           stateNext_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] flashCnt_r;
  logic             flash_r;
  logic [DW-1:0]    curDir_r;
  logic [DW-1:0]    nextDir_r;
  logic [DW-1:0]    pickDir_s;
  logic             anyOther_s;
  logic             leaveGreen_s;
  logic [N_DIR-1:0] served_s;

  rr_next_dir #(
    .N_DIR (N_DIR),
    .DW    (DW)
  ) u_pick (
    .req     (car),
    .cur     (curDir_r),
    .nextIdx (pickDir_s),
    .anyReq  (anyOther_s)
  );

  assign served_s = ONE_HOT0 << curDir_r;

  // Night, gap-out and max-out all end a green the same way.
  assign leaveGreen_s = (night && (timer_r >= GMIN_LAST)) ||
                        (anyOther_s && !car[curDir_r] && (timer_r >= GMIN_LAST)) ||
                        (anyOther_s && (timer_r >= GMAX_LAST));

  // Next-state selection.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      ST_GREEN: begin
        if (leaveGreen_s) stateNext_s = ST_YELLOW;
        else              stateNext_s = ST_GREEN;
      end
      ST_YELLOW: begin
        if (timer_r >= YEL_LAST) stateNext_s = ST_ALLRED;
        else                     stateNext_s = ST_YELLOW;
      end
      ST_ALLRED: begin
        if (timer_r >= AR_LAST) stateNext_s = night ? ST_FLASH : ST_GREEN;
        else                    stateNext_s = ST_ALLRED;
      end
      ST_FLASH: begin
        if (!night) stateNext_s = ST_ALLRED;
        else        stateNext_s = ST_FLASH;
      end
      default: stateNext_s = ST_GREEN;
    endcase
  end

  // State, phase timer and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_GREEN;
      timer_r   <= {CNT_W{1'b0}};
      curDir_r  <= {DW{1'b0}};
      nextDir_r <= {DW{1'b0}};
    end else begin
      state_r <= stateNext_s;
      if (stateNext_s != state_r) timer_r <= {CNT_W{1'b0}};
      else if (timer_r != CNT_MAX) timer_r <= timer_r + CNT_ONE;
      else timer_r <= timer_r;
      if (state_r == ST_GREEN && stateNext_s == ST_YELLOW) nextDir_r <= pickDir_s;
      else if (state_r == ST_FLASH && stateNext_s == ST_ALLRED) nextDir_r <= {DW{1'b0}};
      else nextDir_r <= nextDir_r;
      if (state_r == ST_ALLRED && stateNext_s == ST_GREEN) curDir_r <= nextDir_r;
      else curDir_r <= curDir_r;
    end
  end

  // Night flash phase: lit on entry, toggles every FLASH_HALF cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_r    <= 1'b0;
      flashCnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_FLASH && stateNext_s == ST_FLASH) begin
      flash_r    <= 1'b1;
      flashCnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_FLASH) begin
      if (flashCnt_r >= FH_LAST) begin
        flash_r    <= ~flash_r;
        flashCnt_r <= {CNT_W{1'b0}};
      end else begin
        flash_r    <= flash_r;
        flashCnt_r <= flashCnt_r + CNT_ONE;
      end
    end else begin
      flash_r    <= flash_r;
      flashCnt_r <= flashCnt_r;
    end
  end

  // Lamp decode of the registered state.
  always_comb begin
    green  = {N_DIR{1'b0}};
    yellow = {N_DIR{1'b0}};
    red    = {N_DIR{1'b1}};
    case (state_r)
      ST_GREEN: begin
        green = served_s;
        red   = ~served_s;
      end
      ST_YELLOW: begin
        yellow = served_s;
        red    = ~served_s;
      end
      ST_ALLRED: red = {N_DIR{1'b1}};
      ST_FLASH:  red = {N_DIR{flash_r}};
      default:   red = {N_DIR{1'b1}};
    endcase
  end

  assign cur_dir = curDir_r;
  assign phase   = state_r;

endmodule

// File: tb/tb_tlc_multiway.sv
// Bench for tlc_multiway: scripted vector table, reset corner cases, and
// randomized traffic against a cycle-count model of the junction rules.
module tb_tlc_multiway;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YC   = 2;
  localparam int AC   = 1;
  localparam int FH   = 2;

  localparam int M_G  = 0;
  localparam int M_Y  = 1;
  localparam int M_AR = 2;
  localparam int M_FL = 3;

  typedef logic [16:0] out_t;
  typedef struct {
    logic [3:0] c;
    logic       n;
    int         reps;
    out_t       exp;
  } vec_t;

  localparam out_t RST_OUT = {4'b0001, 4'b0000, 4'b1110, 2'd0, 3'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic       night;
  logic [3:0] car;
  logic [3:0] green, yellow, red;
  logic [1:0] cur_dir;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  int mMode, mAge, mCur, mNext;

  vec_t tbl[$];

  tlc_multiway #(
    .N_DIR      (N),
    .CNT_W      (8),
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_CYC (YC),
    .ALLRED_CYC (AC),
    .FLASH_HALF (FH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .car     (car),
    .night   (night),
    .green   (green),
    .yellow  (yellow),
    .red     (red),
    .cur_dir (cur_dir),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  function automatic out_t dutOut();
    return {green, yellow, red, cur_dir, phase};
  endfunction

  function automatic vec_t mk(logic [3:0] c, logic n, int reps, logic [3:0] g,
                              logic [3:0] y, logic [3:0] r, logic [1:0] d, logic [2:0] p);
    vec_t v;
    v.c = c; v.n = n; v.reps = reps; v.exp = {g, y, r, d, p};
    return v;
  endfunction

  // Model: mode, cycles since entering it, served and latched directions.
  task automatic modelReset();
    mMode = M_G; mAge = 0; mCur = 0; mNext = 0;
  endtask

  function automatic int pickNext(int carV, int cur);
    for (int k = 1; k < N; k++)
      if (((carV >> ((cur + k) % N)) & 1) != 0) return (cur + k) % N;
    return cur;
  endfunction

  task automatic modelStep(int carV, int nightV);
    int others, newMode;
    bit mine;
    others  = carV & ~(1 << mCur);
    mine    = ((carV >> mCur) & 1) != 0;
    newMode = mMode;
    case (mMode)
      M_G: if ((nightV != 0 && mAge >= GMIN - 1) ||
               (others != 0 && !mine && mAge >= GMIN - 1) ||
               (others != 0 && mAge >= GMAX - 1)) begin
        newMode = M_Y;
        mNext   = pickNext(carV, mCur);
      end
      M_Y: if (mAge >= YC - 1) newMode = M_AR;
      M_AR: if (mAge >= AC - 1) begin
        if (nightV != 0) newMode = M_FL;
        else begin newMode = M_G; mCur = mNext; end
      end
      M_FL: if (nightV == 0) begin newMode = M_AR; mNext = 0; end
      default: newMode = M_G;
    endcase
    if (newMode != mMode) mAge = 0;
    else mAge++;
    mMode = newMode;
  endtask

  function automatic out_t modelOut();
    logic [3:0] oh, g, y, r;
    oh = 4'(1 << mCur);
    g = 4'b0000; y = 4'b0000; r = 4'b1111;
    case (mMode)
      M_G:  begin g = oh; r = ~oh; end
      M_Y:  begin y = oh; r = ~oh; end
      M_FL: r = (((mAge / FH) % 2) == 0) ? 4'b1111 : 4'b0000;
      default: r = 4'b1111;
    endcase
    return {g, y, r, 2'(mCur), 3'(mMode)};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got {g,y,r,dir,ph}=%b_%b_%b_%0d_%0d want %b_%b_%b_%0d_%0d",
               name, $time, act[16:13], act[12:9], act[8:5], act[4:3], act[2:0],
               exp[16:13], exp[12:9], exp[8:5], exp[4:3], exp[2:0]);
    end
  endtask

  task automatic tick(input logic [3:0] c, input logic n);
    car = c; night = n;
    @(posedge clk);
    #1;
    modelStep(int'(c), int'(n));
  endtask

  task automatic doReset(input logic [3:0] c);
    reset = 1'b1; car = c; night = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelReset();
    check("reset_hold", dutOut(), RST_OUT);
    reset = 1'b0;
    #1;
    check("reset_release", dutOut(), RST_OUT);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rc;
    logic       rn;

    // Idle junction: dir0 green held forever.
    doReset(4'b0000);
    for (int i = 0; i < 50; i++) begin
      tick(4'b0000, 1'b0);
      check("idle_hold", dutOut(), RST_OUT);
    end

    //        car      night reps green    yellow   red      dir  phase
    tbl.push_back(mk(4'b0101, 1'b0, 7, 4'b0001, 4'b0000, 4'b1110, 2'd0, 3'd0)); // max-out
    tbl.push_back(mk(4'b0101, 1'b0, 2, 4'b0000, 4'b0001, 4'b1110, 2'd0, 3'd1));
    tbl.push_back(mk(4'b0101, 1'b0, 1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 3'd2));
    tbl.push_back(mk(4'b0101, 1'b0, 1, 4'b0100, 4'b0000, 4'b1011, 2'd2, 3'd0));
    tbl.push_back(mk(4'b0000, 1'b1, 3, 4'b0100, 4'b0000, 4'b1011, 2'd2, 3'd0)); // night
    tbl.push_back(mk(4'b0000, 1'b1, 2, 4'b0000, 4'b0100, 4'b1011, 2'd2, 3'd1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 4'b1111, 2'd2, 3'd2));
    tbl.push_back(mk(4'b0000, 1'b1, 2, 4'b0000, 4'b0000, 4'b1111, 2'd2, 3'd3));
    tbl.push_back(mk(4'b0000, 1'b1, 2, 4'b0000, 4'b0000, 4'b0000, 2'd2, 3'd3));
    tbl.push_back(mk(4'b0000, 1'b1, 2, 4'b0000, 4'b0000, 4'b1111, 2'd2, 3'd3));
    tbl.push_back(mk(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b1111, 2'd2, 3'd2));
    tbl.push_back(mk(4'b0000, 1'b0, 1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 3'd0));
    tbl.push_back(mk(4'b0010, 1'b0, 3, 4'b0001, 4'b0000, 4'b1110, 2'd0, 3'd0)); // gap-out
    tbl.push_back(mk(4'b0010, 1'b0, 2, 4'b0000, 4'b0001, 4'b1110, 2'd0, 3'd1));
    tbl.push_back(mk(4'b0010, 1'b0, 1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 3'd2));
    tbl.push_back(mk(4'b0010, 1'b0, 1, 4'b0010, 4'b0000, 4'b1101, 2'd1, 3'd0));
    tbl.push_back(mk(4'b1000, 1'b0, 3, 4'b0010, 4'b0000, 4'b1101, 2'd1, 3'd0));
    tbl.push_back(mk(4'b1000, 1'b0, 2, 4'b0000, 4'b0010, 4'b1101, 2'd1, 3'd1));
    tbl.push_back(mk(4'b1000, 1'b0, 1, 4'b0000, 4'b0000, 4'b1111, 2'd1, 3'd2));
    tbl.push_back(mk(4'b1000, 1'b0, 1, 4'b1000, 4'b0000, 4'b0111, 2'd3, 3'd0));
    tbl.push_back(mk(4'b1001, 1'b0, 7, 4'b1000, 4'b0000, 4'b0111, 2'd3, 3'd0)); // wrap to dir0
    tbl.push_back(mk(4'b1001, 1'b0, 1, 4'b0000, 4'b1000, 4'b0111, 2'd3, 3'd1));
    tbl.push_back(mk(4'b0110, 1'b0, 1, 4'b0000, 4'b1000, 4'b0111, 2'd3, 3'd1)); // latched pick
    tbl.push_back(mk(4'b0110, 1'b0, 1, 4'b0000, 4'b0000, 4'b1111, 2'd3, 3'd2));
    tbl.push_back(mk(4'b0110, 1'b0, 1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 3'd0));

    doReset(4'b0101);
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        tick(tbl[i].c, tbl[i].n);
        check($sformatf("vec%0d_%0d", i, r), dutOut(), tbl[i].exp);
      end
    end

    // Reach yellow on dir2, then pulse reset between clock edges.
    for (int i = 0; i < 40 && !(cur_dir == 2'd2 && phase == 3'd0); i++) tick(4'b0100, 1'b0);
    check("reach_dir2", out_t'({cur_dir, phase}), out_t'({2'd2, 3'd0}));
    for (int i = 0; i < 40 && phase != 3'd1; i++) tick(4'b0001, 1'b0);
    check("reach_yellow", out_t'({cur_dir, phase}), out_t'({2'd2, 3'd1}));
    tick(4'b0001, 1'b0);
    check("mid_yellow", dutOut(), modelOut());
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dutOut(), RST_OUT);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    check("post_reset", dutOut(), RST_OUT);

    // Randomized traffic and night requests against the model.
    rc = 4'(($urandom_range(0, 15)));
    rn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) rn = ~rn;
      tick(rc, rn);
      check("rand", dutOut(), modelOut());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
